// File: rtl/me_search_engine.sv
// ---------------------------------------------------------------------------
// me_search_engine
//   Full-search block-matching motion estimator. One BLK x BLK reference
//   block is matched against every candidate offset in a (BLK+2*RANGE)^2
//   search window. NLANE horizontally adjacent candidates are evaluated per
//   pass. The minimum SAD and its motion vector are reported.
//
//   Optional feature: define ME_EARLY_TERM_EN to abort a pass at a row end
//   once no lane can still beat the running best. The result is unchanged;
//   only latency shrinks.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a search (sampled only while idle)
//   busy, done        search in progress / one-cycle completion pulse
//   ref_addr, ref_rd  reference block read port (raster r*BLK+c)
//   ref_data          reference pixel, one cycle after its address
//   srch_addr, srch_rd search window read port (y*W+x of lane 0)
//   srch_data         NLANE window pixels, lane 0 in the LSBs
//   best_sad          minimum SAD, held until the next start
//   mv_x, mv_y        signed motion vector of best_sad, held
// ---------------------------------------------------------------------------
module me_search_engine #(
    parameter int PIX_W = 8,
    parameter int BLK   = 16,
    parameter int RANGE = 8,
    parameter int NLANE = 4,
    parameter int SAD_W = 16
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           start,
    output logic                                           busy,
    output logic                                           done,
    output logic [$clog2(BLK*BLK)-1:0]                     ref_addr,
    output logic                                           ref_rd,
    input  logic [PIX_W-1:0]                               ref_data,
    output logic [$clog2((BLK+2*RANGE)*(BLK+2*RANGE))-1:0] srch_addr,
    output logic                                           srch_rd,
    input  logic [NLANE*PIX_W-1:0]                         srch_data,
    output logic [SAD_W-1:0]                               best_sad,
    output logic signed [$clog2(RANGE):0]                  mv_x,
    output logic signed [$clog2(RANGE):0]                  mv_y
);
    localparam int LOG_BLK = $clog2(BLK);
    localparam int AW      = $clog2(BLK*BLK);
    localparam int W       = BLK + 2*RANGE;
    localparam int SW      = $clog2(W*W);
    localparam int MV_W    = $clog2(RANGE) + 1;
    localparam int VW      = $clog2(2*RANGE);
    localparam int LAST_VX = 2*RANGE - NLANE;
    localparam int LAST_VY = 2*RANGE - 1;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_CMP, S_DONE} state_t;

    function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                   input logic [PIX_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [SAD_W-1:0] sat_add(input logic [SAD_W-1:0] a,
                                                  input logic [PIX_W-1:0] d);
        logic [SAD_W:0] s;
        s = {1'b0, a} + (SAD_W+1)'(d);
        return s[SAD_W] ? {SAD_W{1'b1}} : s[SAD_W-1:0];
    endfunction

    // Window address of pixel (r, c) of the candidate whose top-left corner
    // sits at window offset (vx, vy); offsets are already RANGE-biased.
    function automatic logic [SW-1:0] srch_at(input logic [VW-1:0]      vy,
                                              input logic [VW-1:0]      vx,
                                              input logic [LOG_BLK-1:0] r,
                                              input logic [LOG_BLK-1:0] c);
        return SW'((int'(vy) + int'(r)) * W + int'(vx) + int'(c));
    endfunction

    function automatic logic signed [MV_W-1:0] to_mv(input logic [VW-1:0] off,
                                                     input int            lane);
        return MV_W'(int'(off) + lane - RANGE);
    endfunction

    state_t           state;
    logic [VW-1:0]    vy_off;
    logic [VW-1:0]    vx_off;
    logic             ab_q;
    logic             vld_p1;
    logic             first_p1;
    logic             abort_now;
    logic [SAD_W-1:0] acc_p2  [NLANE];
    logic [SAD_W-1:0] acc_nxt [NLANE];

    logic [AW-1:0]           k_nxt;
    logic [SW-1:0]           srch_nxt;
    logic [SW-1:0]           nxt_base;
    logic                    last_pass;
    logic [VW-1:0]           nxt_vx;
    logic [VW-1:0]           nxt_vy;
    logic [SAD_W-1:0]        cmp_sad;
    logic signed [MV_W-1:0]  cmp_mvx;
    logic                    cmp_win;

    // Stage p0: address generation for the next raster read and next pass
    always_comb begin
        k_nxt    = ref_addr + AW'(1);
        srch_nxt = srch_at(vy_off, vx_off, k_nxt[AW-1:LOG_BLK], k_nxt[LOG_BLK-1:0]);
        last_pass = (vy_off == VW'(LAST_VY)) && (vx_off == VW'(LAST_VX));
        if (vx_off == VW'(LAST_VX)) begin
            nxt_vx = '0;
            nxt_vy = vy_off + VW'(1);
        end else begin
            nxt_vx = vx_off + VW'(NLANE);
            nxt_vy = vy_off;
        end
        nxt_base = srch_at(nxt_vy, nxt_vx, '0, '0);
    end

    // Stage p1: returned data -> per-lane |ref - srch|, load on first pixel
    always_comb begin
        for (int i = 0; i < NLANE; i++) begin
            acc_nxt[i] = first_p1
                ? SAD_W'(abs_diff(ref_data, srch_data[i*PIX_W +: PIX_W]))
                : sat_add(acc_p2[i], abs_diff(ref_data, srch_data[i*PIX_W +: PIX_W]));
        end
    end

`ifdef ME_EARLY_TERM_EN
    logic [LOG_BLK-1:0] col_p1;
    logic               all_ge;

    // SADs never decrease, so a lane whose partial sum already reached the
    // running best can no longer win with a strict less-than compare.
    always_comb begin
        all_ge = 1'b1;
        for (int i = 0; i < NLANE; i++) begin
            if (acc_nxt[i] < best_sad) all_ge = 1'b0;
        end
    end

    assign abort_now = vld_p1 && (col_p1 == LOG_BLK'(BLK-1)) && all_ge;

    always_ff @(posedge clk) begin
        col_p1 <= ref_addr[LOG_BLK-1:0];
    end
`else
    assign abort_now = 1'b0;
`endif

    // Stage p2: lane compare against the running best, lowest lane first
    always_comb begin
        cmp_sad = best_sad;
        cmp_mvx = mv_x;
        cmp_win = 1'b0;
        for (int i = 0; i < NLANE; i++) begin
            if (acc_p2[i] < cmp_sad) begin
                cmp_sad = acc_p2[i];
                cmp_mvx = to_mv(vx_off, i);
                cmp_win = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        first_p1 <= (ref_addr == '0);
        if (vld_p1) begin
            for (int i = 0; i < NLANE; i++) acc_p2[i] <= acc_nxt[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            best_sad  <= '1;
            mv_x      <= '0;
            mv_y      <= '0;
            ref_addr  <= '0;
            srch_addr <= '0;
            ref_rd    <= 1'b0;
            srch_rd   <= 1'b0;
            vy_off    <= '0;
            vx_off    <= '0;
            ab_q      <= 1'b0;
            vld_p1    <= 1'b0;
        end else begin
            // A read in flight when a pass aborts is marked invalid here.
            vld_p1 <= ref_rd && !abort_now;
            done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        best_sad  <= '1;
                        mv_x      <= MV_W'(-RANGE);
                        mv_y      <= MV_W'(-RANGE);
                        vy_off    <= '0;
                        vx_off    <= '0;
                        ref_addr  <= '0;
                        srch_addr <= '0;
                        ref_rd    <= 1'b1;
                        srch_rd   <= 1'b1;
                        ab_q      <= 1'b0;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (abort_now || ref_addr == '1) begin
                        ref_rd  <= 1'b0;
                        srch_rd <= 1'b0;
                        ab_q    <= abort_now;
                        state   <= S_DRAIN;
                    end else begin
                        ref_addr  <= k_nxt;
                        srch_addr <= srch_nxt;
                    end
                end
                S_DRAIN, S_CMP: begin
                    if (state == S_CMP) begin
                        best_sad <= cmp_sad;
                        mv_x     <= cmp_mvx;
                        if (cmp_win) mv_y <= to_mv(vy_off, 0);
                    end
                    if (state == S_DRAIN && !(ab_q || abort_now)) begin
                        state <= S_CMP;
                    end else if (last_pass) begin
                        state <= S_DONE;
                    end else begin
                        vx_off    <= nxt_vx;
                        vy_off    <= nxt_vy;
                        ref_addr  <= '0;
                        srch_addr <= nxt_base;
                        ref_rd    <= 1'b1;
                        srch_rd   <= 1'b1;
                        ab_q      <= 1'b0;
                        state     <= S_FETCH;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_me_search_engine.sv
// ---------------------------------------------------------------------------
// tb_me_search_engine
//   Drives me_search_engine (default parameters, plus a SAD_W=10 instance for
//   saturation) from behavioural memories and checks every search against a
//   plain nested-loop full-search model.
// ---------------------------------------------------------------------------
module tb_me_search_engine;
    localparam int PIX_W = 8;
    localparam int BLK   = 16;
    localparam int RANGE = 8;
    localparam int NLANE = 4;
    localparam int SAD_W = 16;
    localparam int W     = BLK + 2*RANGE;
    localparam int MV_W  = $clog2(RANGE) + 1;
    localparam int AW    = $clog2(BLK*BLK);
    localparam int SW    = $clog2(W*W);
    localparam int NPX   = 2*RANGE/NLANE;
    localparam int NPASS = 2*RANGE*NPX;
    localparam int LAT   = NPASS*(BLK*BLK+2) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic start2 = 1'b0;

    logic                    busy, done, ref_rd, srch_rd;
    logic [AW-1:0]           ref_addr;
    logic [SW-1:0]           srch_addr;
    logic [PIX_W-1:0]        ref_data = '0;
    logic [NLANE*PIX_W-1:0]  srch_data = '0;
    logic [SAD_W-1:0]        best_sad;
    logic signed [MV_W-1:0]  mv_x, mv_y;

    logic                    busy2, done2, ref_rd2, srch_rd2;
    logic [AW-1:0]           ref_addr2;
    logic [SW-1:0]           srch_addr2;
    logic [PIX_W-1:0]        ref_data2 = 8'hFF;
    logic [NLANE*PIX_W-1:0]  srch_data2 = '0;
    logic [9:0]              best_sad2;
    logic signed [MV_W-1:0]  mv_x2, mv_y2;

    me_search_engine #(.PIX_W(PIX_W), .BLK(BLK), .RANGE(RANGE), .NLANE(NLANE), .SAD_W(SAD_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .ref_addr(ref_addr), .ref_rd(ref_rd), .ref_data(ref_data),
        .srch_addr(srch_addr), .srch_rd(srch_rd), .srch_data(srch_data),
        .best_sad(best_sad), .mv_x(mv_x), .mv_y(mv_y)
    );

    me_search_engine #(.PIX_W(PIX_W), .BLK(BLK), .RANGE(RANGE), .NLANE(NLANE), .SAD_W(10)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
        .ref_addr(ref_addr2), .ref_rd(ref_rd2), .ref_data(ref_data2),
        .srch_addr(srch_addr2), .srch_rd(srch_rd2), .srch_data(srch_data2),
        .best_sad(best_sad2), .mv_x(mv_x2), .mv_y(mv_y2)
    );

    always #5 clk = ~clk;

    logic [7:0] ref_mem [BLK*BLK];
    logic [7:0] win     [W*W];

    // Synchronous-read memories: data appears the cycle after the address.
    always @(posedge clk) begin
        if (ref_rd) ref_data <= ref_mem[ref_addr];
        if (srch_rd) begin
            for (int i = 0; i < NLANE; i++)
                srch_data[i*PIX_W +: PIX_W] <= (int'(srch_addr) + i < W*W) ? win[int'(srch_addr) + i] : 8'h00;
        end
    end

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Full search in raster candidate order; a candidate wins only when
    // strictly better, so the first minimum in that order is kept.
    task automatic model(input int satmax, output int bsad, output int bx, output int by);
        int s, d;
        bsad = satmax;
        bx = -RANGE;
        by = -RANGE;
        for (int vy = -RANGE; vy < RANGE; vy++) begin
            for (int vx = -RANGE; vx < RANGE; vx++) begin
                s = 0;
                for (int r = 0; r < BLK; r++) begin
                    for (int c = 0; c < BLK; c++) begin
                        d = int'(ref_mem[r*BLK+c]) - int'(win[(vy+RANGE+r)*W + vx+RANGE+c]);
                        s += (d < 0) ? -d : d;
                    end
                end
                if (s > satmax) s = satmax;
                if (s < bsad) begin
                    bsad = s;
                    bx = vx;
                    by = vy;
                end
            end
        end
    endtask

    // Search bookkeeping shared between the stimulus and the compare process
    int exp_sad, exp_x, exp_y;
    int t_acc;
    bit active = 1'b0;
    int done_cnt = 0;
    int addr_bad, busy_bad, nreads, pass_idx, prev_k;
    int lat, k_now, vy_now, vx_now, a_exp;

    // Compare process: protocol every cycle, results on the done pulse.
    initial forever begin
        @(negedge clk);
        if (active) begin
            if (ref_rd !== srch_rd) addr_bad++;
            if (ref_rd) begin
                k_now = int'(ref_addr);
                if (k_now == 0) pass_idx++;
                else if (k_now != prev_k + 1) addr_bad++;
                prev_k = k_now;
                vy_now = pass_idx / NPX - RANGE;
                vx_now = (pass_idx % NPX) * NLANE - RANGE;
                a_exp  = (vy_now + RANGE + k_now / BLK) * W + vx_now + RANGE + k_now % BLK;
                if (int'(srch_addr) != a_exp || pass_idx >= NPASS) addr_bad++;
                nreads++;
            end
            if (done) begin
                lat = cyc - t_acc;
                chk("best_sad", best_sad, exp_sad);
                chk("mv_x", $signed(mv_x), exp_x);
                chk("mv_y", $signed(mv_y), exp_y);
                chk("busy_at_done", busy, 0);
                chk("addr_seq_errs", addr_bad, 0);
                chk("busy_gaps", busy_bad, 0);
`ifdef ME_EARLY_TERM_EN
                chk("latency_shorter", (lat < LAT) ? 1 : 0, 1);
                chk("reads_bounded", (nreads > 0 && nreads <= NPASS*BLK*BLK) ? 1 : 0, 1);
`else
                chk("latency", lat, LAT);
                chk("read_count", nreads, NPASS*BLK*BLK);
`endif
                done_cnt++;
                active = 1'b0;
            end else if (!busy) begin
                busy_bad++;
            end
        end
    end

    int d2_cnt = 0;
    int d2_lat = 0;
    initial forever begin
        @(negedge clk);
        if (done2) begin
            d2_cnt++;
            d2_lat = cyc - t_acc;
        end
    end

    task automatic launch(input bit both);
        @(negedge clk);
        start  = 1'b1;
        start2 = both;
        @(posedge clk);
        #1;
        start    = 1'b0;
        start2   = 1'b0;
        t_acc    = cyc;
        addr_bad = 0;
        busy_bad = 0;
        nreads   = 0;
        pass_idx = -1;
        prev_k   = -1;
        active   = 1'b1;
    endtask

    task automatic wait_done();
        int n = 0;
        while (active && n < LAT + 50) begin
            @(posedge clk);
            n++;
        end
        if (active) begin
            chk("done_timeout", 0, 1);
            active = 1'b0;
        end
    endtask

    task automatic fill_exact();
        for (int i = 0; i < BLK*BLK; i++) ref_mem[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < W*W; i++) win[i] = 8'($urandom_range(0, 255));
        for (int r = 0; r < BLK; r++)
            for (int c = 0; c < BLK; c++)
                win[(-2+RANGE+r)*W + 3+RANGE+c] = ref_mem[r*BLK+c];
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_best_sad"}, best_sad, 16'hFFFF);
        chk({tag, "_mv_x"}, $signed(mv_x), 0);
        chk({tag, "_mv_y"}, $signed(mv_y), 0);
        chk({tag, "_ref_addr"}, ref_addr, 0);
        chk({tag, "_srch_addr"}, srch_addr, 0);
        chk({tag, "_ref_rd"}, ref_rd, 0);
        chk({tag, "_srch_rd"}, srch_rd, 0);
    endtask

    int msad, mx, my, dc0;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst");
        chk("rst_sat_best_sad", best_sad2, 10'h3FF);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Exact match at (3,-2), with start re-pulsed at edges 100 and 8000
        fill_exact();
        model(65535, msad, mx, my);
        chk("model_exact_sad", msad, 0);
        chk("model_exact_x", mx, 3);
        chk("model_exact_y", my, -2);
        exp_sad = msad; exp_x = mx; exp_y = my;
        dc0 = done_cnt;
        launch(1'b0);
        repeat (99) @(posedge clk);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (7899) @(posedge clk);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_done();
        repeat (20) @(posedge clk);
        #1;
        chk("single_done", done_cnt, dc0 + 1);
        chk("done_low_after", done, 0);
        chk("busy_low_after", busy, 0);
        chk("held_sad", best_sad, 0);
        chk("held_mv_x", $signed(mv_x), 3);
        chk("held_mv_y", $signed(mv_y), -2);

        // All-zero data (tie rule) alongside the saturating SAD_W=10 instance
        for (int i = 0; i < BLK*BLK; i++) ref_mem[i] = 8'h00;
        for (int i = 0; i < W*W; i++) win[i] = 8'h00;
        model(65535, msad, mx, my);
        chk("model_zero_sad", msad, 0);
        chk("model_zero_x", mx, -8);
        chk("model_zero_y", my, -8);
        exp_sad = msad; exp_x = mx; exp_y = my;
        d2_cnt = 0;
        launch(1'b1);
        wait_done();
        repeat (20) @(posedge clk);
        #1;
        chk("sat_done_count", d2_cnt, 1);
        chk("sat_best_sad", best_sad2, 1023);
        chk("sat_mv_x", $signed(mv_x2), -8);
        chk("sat_mv_y", $signed(mv_y2), -8);
`ifdef ME_EARLY_TERM_EN
        chk("sat_latency_shorter", (d2_lat < LAT) ? 1 : 0, 1);
`else
        chk("sat_latency", d2_lat, LAT);
`endif

        // Reset mid-search, then rerun the exact-match case
        fill_exact();
        model(65535, msad, mx, my);
        exp_sad = msad; exp_x = mx; exp_y = my;
        launch(1'b0);
        repeat (4999) @(posedge clk);
        #2;
        active = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_reset_values("abort");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        launch(1'b0);
        wait_done();

        // Random window with a noisy copy of the block at a random offset
        for (int i = 0; i < BLK*BLK; i++) ref_mem[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < W*W; i++) win[i] = 8'($urandom_range(0, 255));
        mx = $urandom_range(0, 2*RANGE-1);
        my = $urandom_range(0, 2*RANGE-1);
        for (int r = 0; r < BLK; r++) begin
            for (int c = 0; c < BLK; c++) begin
                msad = int'(ref_mem[r*BLK+c]) + int'($urandom_range(0, 3));
                win[(my+r)*W + mx+c] = 8'((msad > 255) ? 255 : msad);
            end
        end
        model(65535, msad, mx, my);
        exp_sad = msad; exp_x = mx; exp_y = my;
        launch(1'b0);
        wait_done();

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
